upsample_writer: RTL and testbench

//  Inverse of the pooling stage: accepts a valid/ready stream of pooled pixels in raster order and

---
 rtl/upsample_writer_if.sv | 48 ++++
 rtl/upsample_writer.sv | 180 ++++++++++++++++++
 tb/tb_upsample_writer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/upsample_writer_if.sv
// Stream-in / banked-RAM-write bus for upsample_writer.
// master = pixel source + RAM observer, slave = upsample_writer.
interface upsample_writer_if #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned SCALE     = 2,
  parameter int unsigned ADDR_W    = 13
);

  // Frame control and pooled-pixel stream
  logic                 start;
  logic [BIT_WIDTH-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  // Banked RAM write port, shared address and data
  logic [BIT_WIDTH-1:0] data_wr;
  logic [ADDR_W-1:0]    addr_wr;
  logic [SCALE-1:0]     wren;

  // Status
  logic                 busy;
  logic                 done;

  modport master (
    output start,
    output in_data,
    output in_valid,
    input  in_ready,
    input  data_wr,
    input  addr_wr,
    input  wren,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  in_data,
    input  in_valid,
    output in_ready,
    output data_wr,
    output addr_wr,
    output wren,
    output busy,
    output done
  );

endinterface

// File: rtl/upsample_writer.sv
// upsample_writer: takes pooled pixels in raster order and writes each as a
// SCALE x SCALE replicated block into SCALE row-interleaved RAM banks.
// Bank b holds output rows with y_out % SCALE == b, so one shared address
// with all banks enabled writes one column of the block per cycle.
// Optional feature macro: UPSAMPLE_WRITER_PIPELINE_EN (accept the next pixel
// during the last write cycle of the current one, removing the wren gap).
module upsample_writer #(
  parameter int unsigned OUT_X     = 128,
  parameter int unsigned OUT_Y     = 128,
  parameter int unsigned SCALE     = 2,
  parameter int unsigned BIT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  upsample_writer_if.slave  bus
);

  localparam int unsigned IN_X   = OUT_X / SCALE;
  localparam int unsigned IN_Y   = OUT_Y / SCALE;
  localparam int unsigned ADDR_W = (IN_Y * OUT_X > 1) ? $clog2(IN_Y * OUT_X) : 1;
  localparam int unsigned X_W    = (IN_X > 1) ? $clog2(IN_X) : 1;
  localparam int unsigned Y_W    = (IN_Y > 1) ? $clog2(IN_Y) : 1;
  localparam int unsigned REP_W  = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [X_W-1:0]   X_LAST   = X_W'(IN_X - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(IN_Y - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(SCALE - 1);

`ifdef UPSAMPLE_WRITER_PIPELINE_EN
  localparam bit PIPE_EN = 1'b1;
`else
  localparam bit PIPE_EN = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]           state_q,    state_d;
  logic [X_W-1:0]       x_in_q,     x_in_d;
  logic [Y_W-1:0]       y_in_q,     y_in_d;
  logic [REP_W-1:0]     rep_q,      rep_d;
  logic [BIT_WIDTH-1:0] pix_q,      pix_d;

  logic                 in_ready_q, in_ready_d;
  logic [BIT_WIDTH-1:0] data_wr_q,  data_wr_d;
  logic [ADDR_W-1:0]    addr_wr_q,  addr_wr_d;
  logic [SCALE-1:0]     wren_q,     wren_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;

  logic                 hs_c;
  logic                 last_pix_c;
  logic                 next_last_pix_c;

  // Handshake and frame-end flags for the current and the next pixel position
  always_comb begin
    hs_c            = bus.in_valid && in_ready_q;
    last_pix_c      = (x_in_q == X_LAST) && (y_in_q == Y_LAST);
    next_last_pix_c = (x_in_d == X_LAST) && (y_in_d == Y_LAST);
  end

  // Next-state, counter and pixel-capture logic
  always_comb begin
    state_d = state_q;
    x_in_d  = x_in_q;
    y_in_d  = y_in_q;
    rep_d   = rep_q;
    pix_d   = pix_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_ACCEPT;
          x_in_d  = '0;
          y_in_d  = '0;
          rep_d   = '0;
        end
      end

      ST_ACCEPT: begin
        if (hs_c) begin
          state_d = ST_WRITE;
          rep_d   = '0;
          pix_d   = bus.in_data;
        end
      end

      ST_WRITE: begin
        if (rep_q == REP_LAST) begin
          if (last_pix_c) begin
            state_d = ST_DONE;
          end else begin
            rep_d = '0;
            if (x_in_q == X_LAST) begin
              x_in_d = '0;
              y_in_d = y_in_q + Y_W'(1);
            end else begin
              x_in_d = x_in_q + X_W'(1);
            end
            // in_ready is only ever high here when pipelining is built in
            if (PIPE_EN && hs_c) begin
              state_d = ST_WRITE;
              pix_d   = bus.in_data;
            end else begin
              state_d = ST_ACCEPT;
            end
          end
        end else begin
          rep_d = rep_q + REP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs derived from the state being entered
  always_comb begin
    wren_d     = '0;
    data_wr_d  = data_wr_q;
    addr_wr_d  = addr_wr_q;
    busy_d     = (state_d == ST_ACCEPT) || (state_d == ST_WRITE);
    done_d     = (state_d == ST_DONE);
    in_ready_d = (state_d == ST_ACCEPT) ||
                 (PIPE_EN && (state_d == ST_WRITE) && (rep_d == REP_LAST) &&
                  !next_last_pix_c);

    if (state_d == ST_WRITE) begin
      wren_d    = '1;
      data_wr_d = pix_d;
      addr_wr_d = ADDR_W'(y_in_d) * ADDR_W'(OUT_X) +
                  ADDR_W'(x_in_d) * ADDR_W'(SCALE) +
                  ADDR_W'(rep_d);
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      x_in_q     <= '0;
      y_in_q     <= '0;
      rep_q      <= '0;
      pix_q      <= '0;
      in_ready_q <= 1'b0;
      data_wr_q  <= '0;
      addr_wr_q  <= '0;
      wren_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_in_q     <= x_in_d;
      y_in_q     <= y_in_d;
      rep_q      <= rep_d;
      pix_q      <= pix_d;
      in_ready_q <= in_ready_d;
      data_wr_q  <= data_wr_d;
      addr_wr_q  <= addr_wr_d;
      wren_q     <= wren_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Drive the bus from the output registers
  always_comb begin
    bus.in_ready = in_ready_q;
    bus.data_wr  = data_wr_q;
    bus.addr_wr  = addr_wr_q;
    bus.wren     = wren_q;
    bus.busy     = busy_q;
    bus.done     = done_q;
  end

endmodule

// File: tb/tb_upsample_writer.sv
// Self-checking bench for upsample_writer (8x4 output, SCALE 2 -> 4x2 input).
module tb_upsample_writer;

  localparam int unsigned OUT_X  = 8;
  localparam int unsigned OUT_Y  = 4;
  localparam int unsigned SCALE  = 2;
  localparam int unsigned BW     = 16;
  localparam int unsigned ADDR_W = 4;

`ifdef UPSAMPLE_WRITER_PIPELINE_EN
  localparam int EXP_SPAN = 16;
`else
  localparam int EXP_SPAN = 23;
`endif

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [BW-1:0]     data;
  } exp_wr_t;

  typedef struct {
    logic [BW-1:0]     pix;
    logic [ADDR_W-1:0] addr0;
  } vec_t;

  logic clk;
  logic rst;

  upsample_writer_if #(.BIT_WIDTH(BW), .SCALE(SCALE), .ADDR_W(ADDR_W)) bus ();

  upsample_writer #(
    .OUT_X    (OUT_X),
    .OUT_Y    (OUT_Y),
    .SCALE    (SCALE),
    .BIT_WIDTH(BW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      checks;
  int      errors;
  int      cyc;
  exp_wr_t exp_q[$];
  vec_t    vecs[8];

  bit      trk_en;
  int      trk_first;
  int      trk_last;
  int      trk_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: sample at the falling edge and score any RAM write seen
  task automatic tick();
    exp_wr_t e;
    @(negedge clk);
    cyc++;
    if (bus.wren != '0) begin
      check("wren_all_banks", 32'(bus.wren), 32'(2'b11));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write",
                 bus.addr_wr, bus.data_wr);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.addr_wr), 32'(e.addr));
        check("wr_data", 32'(bus.data_wr), 32'(e.data));
      end
      if (trk_en) begin
        if (trk_first < 0) trk_first = cyc;
        trk_last = cyc;
        trk_cnt++;
      end
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Offer one pixel after 'gap' idle cycles; expect nexp writes from base
  task automatic send(input logic [BW-1:0] d, input int gap,
                      input logic [ADDR_W-1:0] base, input int nexp);
    exp_wr_t e;
    int      n;
    bus.in_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("handshake_ready", 32'(bus.in_ready), 32'(1'b1));
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      return;
    end
    for (int i = 0; i < nexp; i++) begin
      e.addr = base + ADDR_W'(i);
      e.data = d;
      exp_q.push_back(e);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    trk_en    = 1'b0;
    trk_first = -1;
    trk_last  = 0;
    trk_cnt   = 0;

    for (int k = 0; k < 8; k++) begin
      vecs[k].pix   = BW'(k + 1);
      vecs[k].addr0 = ADDR_W'((k / 4) * 8 + (k % 4) * 2);
    end

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;

    // Test 1: reset held, in_valid ignored
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ctrl", 32'({bus.in_ready, bus.busy, bus.done, bus.wren}), 32'(0));
      check("rst_bus", 32'({bus.addr_wr, bus.data_wr}), 32'(0));
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_ready", 32'({bus.in_ready, bus.busy}), 32'(0));
    end
    bus.in_valid = 1'b0;

    // Test 2: single pixel, then start while busy is ignored
    do_start();
    check("start_ready", 32'(bus.in_ready), 32'(1'b1));
    check("start_busy", 32'(bus.busy), 32'(1'b1));
    send(16'h1234, 0, ADDR_W'(0), 2);
    tick();
    tick();
    check("t2_ready_after", 32'(bus.in_ready), 32'(1'b1));
    check("t2_wren_idle", 32'(bus.wren), 32'(0));
    check("t2_q_empty", 32'(exp_q.size()), 32'(0));
    do_start();
    send(16'h5678, 0, ADDR_W'(2), 2);
    tick();
    tick();
    check("t2_busy_start_ignored", 32'(exp_q.size()), 32'(0));

    // Test 3: full frame, back-to-back pixels
    do_reset();
    do_start();
    for (int k = 0; k < 8; k++) send(vecs[k].pix, 0, vecs[k].addr0, 2);
    tick();
    tick();
    check("t3_done", 32'(bus.done), 32'(1'b1));
    check("t3_busy", 32'(bus.busy), 32'(1'b0));
    check("t3_ready", 32'(bus.in_ready), 32'(1'b0));
    check("t3_q_empty", 32'(exp_q.size()), 32'(0));
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_done_held", 32'({bus.done, bus.in_ready}), 32'(2'b10));
    end
    bus.in_valid = 1'b0;

    // Test 4: restart from DONE, 3 idle cycles between pixels
    do_start();
    check("t4_done_cleared", 32'(bus.done), 32'(1'b0));
    check("t4_busy", 32'(bus.busy), 32'(1'b1));
    for (int k = 0; k < 8; k++) send(~vecs[k].pix, 3, vecs[k].addr0, 2);
    tick();
    tick();
    check("t4_done", 32'(bus.done), 32'(1'b1));
    check("t4_q_empty", 32'(exp_q.size()), 32'(0));

    // Test 5: reset during first write cycle aborts the pixel
    do_reset();
    do_start();
    send(16'hAAAA, 0, ADDR_W'(0), 1);
    rst = 1'b1;
    tick();
    check("t5_wren_after_rst", 32'(bus.wren), 32'(0));
    check("t5_state_after_rst", 32'({bus.in_ready, bus.busy, bus.addr_wr}), 32'(0));
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("t5_no_addr1", 32'(exp_q.size()), 32'(0));
    do_start();
    send(16'hBEEF, 0, ADDR_W'(0), 2);
    tick();
    tick();
    check("t5_beef_done", 32'(exp_q.size()), 32'(0));

    // Test 6: continuous in_valid throughput
    do_reset();
    do_start();
    trk_en = 1'b1;
    for (int k = 0; k < 8; k++) send(vecs[k].pix, 0, vecs[k].addr0, 2);
    for (int i = 0; i < 4; i++) tick();
    trk_en = 1'b0;
    check("t6_wr_count", 32'(trk_cnt), 32'(16));
    check("t6_span", 32'(trk_last - trk_first + 1), 32'(EXP_SPAN));
    check("t6_done", 32'(bus.done), 32'(1'b1));
    check("t6_q_empty", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
